// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-memory / memory-mapped output port stage.
// Status word layout: bit 0 empty, bit 1 full, count from bit 2 upward.
package data_mem_io_pkg;

  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_COUNT = 2;

  localparam int DROP_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clrState_t;

endpackage

// File: rtl/data_mem_io_fifo.sv
// Show-ahead output FIFO: head visible one cycle after a push into an empty FIFO.
// A push while full is refused unless a pop frees a slot in the same cycle.
module io_out_fifo #(
  parameter int BITS      = 16,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [BITS-1:0]      pushData,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_LOG2:0]   count,
  output logic [BITS-1:0]      head
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [BITS-1:0]      mem [DEPTH];
  logic [FIFO_LOG2-1:0] wrPtr;
  logic [FIFO_LOG2-1:0] rdPtr;
  logic                 doPush;
  logic                 doPop;

  assign empty  = (count == '0);
  assign full   = (count == (FIFO_LOG2+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  // Storage is not reset, so mask the head to keep the output clean when empty.
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/data_mem_io.sv
// CPU data port: word RAM with zero-latency loads plus a memory-mapped output FIFO.
// Optional power-on RAM clear is built when MEM_CLEAR_EN is defined.
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int              BITS      = 16,
  parameter int              AW        = 8,
  parameter logic [BITS-1:0] IO_ADDR   = BITS'(IO_ADDR_DEF),
  parameter int              FIFO_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   mem_addr,
  input  logic [BITS-1:0]   mem_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [BITS-1:0]   mem_data_out,
  output logic              io_valid,
  output logic [BITS-1:0]   io_data,
  input  logic              io_ready,
  output logic [DROP_W-1:0] io_drop_cnt,
  output logic              init_busy
);

  logic                 isIo;
  logic                 ioPush;
  logic                 ioPop;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [FIFO_LOG2:0]   fifoCount;
  logic [BITS-1:0]      status;
  logic [BITS-1:0]      ramRdata;
  logic [BITS-1:0]      ramWdata;
  logic [AW-1:0]        ramWaddr;
  logic                 ramWe;
  logic                 clearing;
  logic [AW-1:0]        clrPtr;
  logic [BITS-1:0]      ram [1 << AW];

  assign isIo     = (mem_addr == IO_ADDR);
  assign ioPush   = mem_wr && isIo;
  assign io_valid = !fifoEmpty;
  assign ioPop    = io_valid && io_ready;

  io_out_fifo #(
    .BITS      (BITS),
    .FIFO_LOG2 (FIFO_LOG2)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ioPush),
    .pushData (mem_data),
    .pop      (ioPop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .head     (io_data)
  );

  always_comb begin
    status                                = '0;
    status[STAT_EMPTY]                    = fifoEmpty;
    status[STAT_FULL]                     = fifoFull;
    status[STAT_COUNT +: FIFO_LOG2+1]     = fifoCount;
  end

  // A push that finds the FIFO full with no pop to make room is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_drop_cnt <= '0;
    end else if (ioPush && fifoFull && !ioPop && (io_drop_cnt != '1)) begin
      io_drop_cnt <= io_drop_cnt + 1'b1;
    end
  end

`ifdef MEM_CLEAR_EN
  clrState_t state;
  logic      busyQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrPtr <= '0;
      busyQ  <= 1'b1;
    end else if (state == CLEAR) begin
      clrPtr <= clrPtr + 1'b1;
      if (clrPtr == '1) begin
        state <= IDLE;
        busyQ <= 1'b0;
      end
    end
  end

  assign clearing  = (state == CLEAR);
  assign init_busy = busyQ;
`else
  assign clrPtr    = '0;
  assign clearing  = 1'b0;
  assign init_busy = 1'b0;
`endif

  // The clear sweep owns the write port; CPU RAM stores are ignored meanwhile.
  assign ramWe    = clearing || (mem_wr && !isIo);
  assign ramWaddr = clearing ? clrPtr : mem_addr[AW-1:0];
  assign ramWdata = clearing ? '0 : mem_data;

  always_ff @(posedge clk) begin
    if (ramWe) ram[ramWaddr] <= ramWdata;
  end

  assign ramRdata = ram[mem_addr[AW-1:0]];

  always_comb begin
    mem_data_out = '0;
    if (mem_rd) begin
      if (isIo)          mem_data_out = status;
      else if (clearing) mem_data_out = '0;
      else               mem_data_out = ramRdata;
    end
  end

endmodule
